pop_count_acc: RTL and testbench
================================

POP_COUNT_ACC -- requirements
Module: pop_count_acc

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, giving the number of 1-bit operand inputs per beat (legal range 2..64).
REQ-002 The block SHALL have parameter ACC_W, default 8, giving the accumulator width, with ACC_W >= clog2(N_IN+1).
REQ-003 The block SHALL have parameter SAT, default 1, where 1 selects saturating accumulation and 0 selects modulo-2^ACC_W wrap.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  beat present on in_bits/in_last.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 in_bits  input  N_IN  operand bits; the beat's value is its count of ones.
REQ-009 in_last  input  1  marks the final beat of a frame.
REQ-010 out_valid  output  1  frame result present on out_count/out_ovf.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_count  output  ACC_W  frame total of ones (saturated or wrapped).
REQ-013 out_ovf  output  1  frame total exceeded 2^ACC_W-1.

Function
REQ-014 The block SHALL accept a beat only on a cycle with in_valid=1 and in_ready=1.
REQ-015 The block SHALL compute the beat value as the popcount of in_bits, width clog2(N_IN+1), zero-extended to ACC_W+1 bits before addition.
REQ-016 The block SHALL implement states IDLE (acc=0, no beat taken), ACCUM (>=1 beat taken, no in_last yet) and HOLD (result presented).
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-018 IDLE/ACCUM with an accepted beat and in_last=0: acc <= acc + popcount; the state SHALL become ACCUM.
REQ-019 IDLE/ACCUM with an accepted beat and in_last=1: out_count <= final sum, out_ovf <= sticky overflow, out_valid <= 1 on the next edge; the state SHALL become HOLD, giving latency 1 cycle from the last beat to out_valid.
REQ-020 A single-beat frame (in_last=1 accepted in IDLE) SHALL be legal and SHALL produce out_count = popcount of that beat.
REQ-021 Overflow SHALL be detected when the ACC_W+1-bit sum exceeds 2^ACC_W-1; a sticky ovf flag SHALL be set for the rest of the frame.
REQ-022 With SAT=1, acc SHALL clamp at 2^ACC_W-1 and stay clamped for the rest of the frame.
REQ-023 With SAT=0, acc SHALL keep the low ACC_W bits of the sum.
REQ-024 In HOLD, out_valid, out_count and out_ovf SHALL stay stable until out_ready=1.
REQ-025 A HOLD cycle with out_ready=1 SHALL cause, on the next edge: out_valid=0, acc=0, sticky ovf=0, state=IDLE.
REQ-026 An input beat presented in the same cycle as the HOLD handshake SHALL NOT be accepted (in_ready=0); it is taken no earlier than the following cycle.
REQ-027 out_ready SHALL be ignored while out_valid=0.
REQ-028 in_valid=0 cycles inside a frame SHALL leave acc and state unchanged.

Reset
REQ-029 While rst_n=0, state=IDLE, acc=0, sticky ovf=0, out_valid=0, out_count=0, out_ovf=0, and in_ready=0.
REQ-030 in_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-031 Reset asserted mid-frame or in HOLD SHALL discard the partial sum and pending result without producing an output.

Verification
REQ-032 N_IN=4, ACC_W=8: all 16 in_bits values sent as single-beat frames -> out_count equals popcount each time (0..4), out_ovf=0, out_valid 1 cycle after each beat.
REQ-033 N_IN=4, ACC_W=8: 3-beat frame 4'b1111, 4'b0101, 4'b0001 (last) with in_valid gaps between beats -> out_count=7, out_ovf=0.
REQ-034 N_IN=4, ACC_W=3, SAT=1: beats 4'b1111, 4'b1111 (last) -> out_count=7, out_ovf=1; the next frame 4'b0001 (last) -> out_count=1, out_ovf=0.
REQ-035 N_IN=4, ACC_W=3, SAT=0: beats 4'b1111, 4'b1111 (last) -> out_count=0, out_ovf=1.
REQ-036 out_ready held 0 for 5 cycles with in_valid=1 -> in_ready=0 and the output stays stable throughout; on the out_ready=1 cycle the pending beat is not taken, and it is accepted on the next cycle.
REQ-037 rst_n pulsed low after 2 beats of a frame -> all outputs 0 immediately; a subsequent single-beat frame 4'b0011 (last) -> out_count=2.

Source files
------------

// File: rtl/pop_count_acc_if.sv
// pop_count_acc_if -- beat-in / frame-result-out bus for pop_count_acc.
//   Parameters: N_IN (operand bits per beat), ACC_W (result width).
//   Input side : in_valid, in_ready, in_bits[N_IN], in_last.
//   Output side: out_valid, out_ready, out_count[ACC_W], out_ovf.
//   master = producer of beats / consumer of results; slave = the accumulator.
interface pop_count_acc_if #(
    parameter int N_IN  = 4,
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_bits;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_bits, in_last, out_ready,
        input  in_ready, out_valid, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_bits, in_last, out_ready,
        output in_ready, out_valid, out_count, out_ovf
    );
endinterface

// File: rtl/pop_count_acc.sv
// pop_count_acc -- counts the ones across all beats of a frame.
//   Each accepted beat adds popcount(in_bits) to a frame accumulator. The beat
//   flagged in_last closes the frame: one cycle later the total is presented on
//   out_count/out_ovf with out_valid, and held until out_ready.
//   SAT=1 clamps the total at 2^ACC_W-1, SAT=0 wraps modulo 2^ACC_W; in both
//   modes out_ovf reports that the true total did not fit in ACC_W bits.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - pop_count_acc_if.slave (beat input and result output handshakes)
module pop_count_acc #(
    parameter int N_IN  = 4,
    parameter int ACC_W = 8,
    parameter int SAT   = 1
) (
    input logic            clk,
    input logic            rst_n,
    pop_count_acc_if.slave bus
);
    localparam int PC_W  = $clog2(N_IN + 1);
    localparam int SUM_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             rdy;
    logic             out_valid;
    logic [ACC_W-1:0] out_count;
    logic             out_ovf;

    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] sum;
    logic             carry;
    logic [ACC_W-1:0] acc_nxt;
    logic             ovf_nxt;
    logic             take;

    always_comb begin
        pc = '0;
        for (int i = 0; i < N_IN; i++)
            pc = pc + PC_W'(bus.in_bits[i]);
    end

    // One extra bit of headroom: the top bit of sum is the overflow carry.
    // Once clamped in SAT mode every further non-zero beat carries again, so
    // the accumulator stays pinned at ACC_MAX without extra state.
    always_comb begin
        sum     = {1'b0, acc} + SUM_W'(pc);
        carry   = sum[ACC_W];
        ovf_nxt = ovf | carry;
        acc_nxt = (SAT != 0 && carry) ? ACC_MAX : sum[ACC_W-1:0];
        take    = bus.in_valid & rdy;
    end

    // in_ready is registered: it is low throughout reset and during HOLD, and
    // comes back one edge after the result handshake, so a beat offered in the
    // handshake cycle is only taken on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            rdy       <= 1'b0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    rdy <= 1'b1;
                    if (take) begin
                        acc <= acc_nxt;
                        ovf <= ovf_nxt;
                        if (bus.in_last) begin
                            out_count <= acc_nxt;
                            out_ovf   <= ovf_nxt;
                            out_valid <= 1'b1;
                            rdy       <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        rdy       <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = out_valid;
    assign bus.out_count = out_count;
    assign bus.out_ovf   = out_ovf;
endmodule

// File: tb/tb_pop_count_acc.sv
// tb_pop_count_acc -- drives three accumulators (ACC_W=8 saturating, ACC_W=3
// saturating, ACC_W=3 wrapping) with one shared beat stream and compares each
// frame result against a reference computed from the plain frame total.
module tb_pop_count_acc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_bits = 4'd0;

    int checks = 0;
    int errors = 0;
    int frame_total = 0;
    int exp_total = 0;

    always #5 clk = ~clk;

    pop_count_acc_if #(.N_IN(4), .ACC_W(8)) if8 ();
    pop_count_acc_if #(.N_IN(4), .ACC_W(3)) if3s ();
    pop_count_acc_if #(.N_IN(4), .ACC_W(3)) if3w ();

    assign if8.in_valid   = in_valid;
    assign if8.in_bits    = in_bits;
    assign if8.in_last    = in_last;
    assign if8.out_ready  = out_ready;
    assign if3s.in_valid  = in_valid;
    assign if3s.in_bits   = in_bits;
    assign if3s.in_last   = in_last;
    assign if3s.out_ready = out_ready;
    assign if3w.in_valid  = in_valid;
    assign if3w.in_bits   = in_bits;
    assign if3w.in_last   = in_last;
    assign if3w.out_ready = out_ready;

    pop_count_acc #(.N_IN(4), .ACC_W(8), .SAT(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    pop_count_acc #(.N_IN(4), .ACC_W(3), .SAT(1)) u3s (.clk(clk), .rst_n(rst_n), .bus(if3s.slave));
    pop_count_acc #(.N_IN(4), .ACC_W(3), .SAT(0)) u3w (.clk(clk), .rst_n(rst_n), .bus(if3w.slave));

    // Reference: a frame result depends only on the true total of ones.
    function automatic int mdl_count(input int total, input int w, input bit sat);
        int mx = (1 << w) - 1;
        if (total <= mx) return total;
        return sat ? mx : (total & mx);
    endfunction

    function automatic int mdl_ovf(input int total, input int w);
        return (total > ((1 << w) - 1)) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int total);
        chk({tag, ".v8"},  32'(if8.out_valid), 1);
        chk({tag, ".c8"},  32'(if8.out_count), mdl_count(total, 8, 1'b1));
        chk({tag, ".o8"},  32'(if8.out_ovf), mdl_ovf(total, 8));
        chk({tag, ".v3s"}, 32'(if3s.out_valid), 1);
        chk({tag, ".c3s"}, 32'(if3s.out_count), mdl_count(total, 3, 1'b1));
        chk({tag, ".o3s"}, 32'(if3s.out_ovf), mdl_ovf(total, 3));
        chk({tag, ".v3w"}, 32'(if3w.out_valid), 1);
        chk({tag, ".c3w"}, 32'(if3w.out_count), mdl_count(total, 3, 1'b0));
        chk({tag, ".o3w"}, 32'(if3w.out_ovf), mdl_ovf(total, 3));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".rdy"}, 32'(if8.in_ready), 0);
        chk({tag, ".v"},   32'(if8.out_valid), 0);
        chk({tag, ".c8"},  32'(if8.out_count), 0);
        chk({tag, ".o8"},  32'(if8.out_ovf), 0);
        chk({tag, ".c3w"}, 32'(if3w.out_count), 0);
        chk({tag, ".o3w"}, 32'(if3w.out_ovf), 0);
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic beat(input logic [3:0] bits, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_bits  = bits;
        in_last  = last;
        while (!if8.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("beat_wait", 32'(n < 50), 1);
        tick();
        frame_total += $countones(bits);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_bits   = 4'($urandom);
        in_last   = 1'($urandom);
        if (last) begin
            exp_total   = frame_total;
            frame_total = 0;
        end
    endtask

    // Idle cycles inside a frame: garbage on the data lines, out_ready toggling.
    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_bits   = 4'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        out_ready = 1'b0;
    endtask

    // Hold the result for k cycles, then complete the output handshake.
    task automatic drain(input int k);
        out_ready = 1'b0;
        repeat (k) begin
            tick();
            check_out("hold", exp_total);
            chk("hold.rdy", 32'(if8.in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rel.v", 32'(if8.out_valid), 0);
        chk("rel.rdy", 32'(if8.in_ready), 1);
    endtask

    initial begin
        logic [3:0] pend;
        int nb;

        // Reset and first in_ready edge
        #12;
        check_zero("rst");
        rst_n = 1'b1;
        #1;
        chk("rst.rdy_low", 32'(if8.in_ready), 0);
        tick();
        chk("rst.rdy_rise", 32'(if8.in_ready), 1);

        // Every 4-bit value as a single-beat frame
        for (int v = 0; v < 16; v++) begin
            beat(4'(v), 1'b1);
            check_out("single", exp_total);
            drain($urandom_range(0, 2));
        end

        // Three beats with gaps: 4 + 2 + 1
        beat(4'b1111, 1'b0);
        gap(2);
        beat(4'b0101, 1'b0);
        gap(3);
        beat(4'b0001, 1'b1);
        check_out("gaps", exp_total);
        chk("gaps.total", 32'(if8.out_count), 7);
        drain(1);

        // Overflow of the narrow accumulators, then a clean frame
        beat(4'b1111, 1'b0);
        beat(4'b1111, 1'b1);
        check_out("ovf", exp_total);
        chk("ovf.sat", 32'(if3s.out_count), 7);
        chk("ovf.wrap", 32'(if3w.out_count), 0);
        drain(0);
        beat(4'b0001, 1'b1);
        check_out("after_ovf", exp_total);
        chk("after_ovf.o3s", 32'(if3s.out_ovf), 0);
        drain(0);

        // Back-pressure with a beat waiting on the input
        beat(4'b0110, 1'b1);
        check_out("bp", exp_total);
        pend     = 4'b1011;
        in_valid = 1'b1;
        in_bits  = pend;
        in_last  = 1'b1;
        repeat (5) begin
            tick();
            check_out("bp.stable", exp_total);
            chk("bp.rdy", 32'(if8.in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp.hs_v", 32'(if8.out_valid), 0);
        chk("bp.hs_rdy", 32'(if8.in_ready), 1);
        tick();
        in_valid  = 1'b0;
        exp_total = $countones(pend);
        check_out("bp.next", exp_total);
        drain(0);

        // Reset in the middle of a frame
        beat(4'b1111, 1'b0);
        beat(4'b0111, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        frame_total = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst.rdy", 32'(if8.in_ready), 1);
        beat(4'b0011, 1'b1);
        check_out("midrst.next", exp_total);
        chk("midrst.two", 32'(if8.out_count), 2);
        drain(0);

        // Reset while a result is held
        beat(4'b1110, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("holdrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Random frames
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                gap($urandom_range(0, 2));
                beat(4'($urandom), 1'(b == nb - 1));
            end
            check_out("rand", exp_total);
            drain($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
